// File: rtl/nbit_mult_sequencer.sv
// Sequential N-bit unsigned multiplier: one row of carry-save cells reused once per multiplier bit.
// Optional early termination on all-zero remaining multiplier bits: define MULT_SEQ_SKIP_ZERO_EN.
module nbit_mult_sequencer #(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [N-1:0]     inputM,
  input  logic [N-1:0]     inputQ,
  output logic             busy,
  output logic             done,
  output logic [2*N-1:0]   product
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     m_q, m_d;
  logic [N-1:0]     a_q, a_d;
  logic [N-1:0]     q_q, q_d;
  logic [CW-1:0]    count_q, count_d;
  logic [2*N-1:0]   product_q, product_d;

  // Cell row: each position adds the gated multiplicand bit into the accumulator with a rippled carry.
  logic [N:0]       carry_c;
  logic [N-1:0]     sum_c;
  logic [N-1:0]     a_nxt, q_nxt;

  assign carry_c[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_cell
    logic pp;
    assign pp           = m_q[i] & q_q[0];
    assign sum_c[i]     = a_q[i] ^ pp ^ carry_c[i];
    assign carry_c[i+1] = (a_q[i] & pp) | (a_q[i] & carry_c[i]) | (pp & carry_c[i]);
  end

  assign a_nxt = {carry_c[N], sum_c[N-1:1]};
  assign q_nxt = {sum_c[0], q_q[N-1:1]};

`ifdef MULT_SEQ_SKIP_ZERO_EN
  // Low N-count bits of the shift register are the multiplier bits not yet consumed.
  logic [N-1:0] rem_mask;
  logic         rem_zero;
  assign rem_mask = {N{1'b1}} >> count_q;
  assign rem_zero = ((q_q & rem_mask) == '0);
`endif

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    a_d       = a_q;
    q_d       = q_q;
    count_d   = count_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = inputM;
          q_d     = inputQ;
          a_d     = '0;
          count_d = '0;
          state_d = ADD;
        end
      end
      ADD: begin
`ifdef MULT_SEQ_SKIP_ZERO_EN
        if (rem_zero) begin
          product_d = {a_q, q_q} >> (N - int'(count_q));
          state_d   = DONE;
        end else begin
          a_d     = a_nxt;
          q_d     = q_nxt;
          count_d = count_q + CW'(1);
          if (count_q == CW'(N - 1)) begin
            product_d = {a_nxt, q_nxt};
            state_d   = DONE;
          end
        end
`else
        a_d     = a_nxt;
        q_d     = q_nxt;
        count_d = count_q + CW'(1);
        if (count_q == CW'(N - 1)) begin
          product_d = {a_nxt, q_nxt};
          state_d   = DONE;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      m_q       <= '0;
      a_q       <= '0;
      q_q       <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      a_q       <= a_d;
      q_q       <= q_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == ADD);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_nbit_mult_sequencer.sv
// Directed bench for nbit_mult_sequencer: N=8 vector table and corner sequences, plus exhaustive N=4.
module tb_nbit_mult_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  inputM, inputQ;
  logic        busy, done;
  logic [15:0] product;

  logic        start4;
  logic [3:0]  m4, q4;
  logic        busy4, done4;
  logic [7:0]  prod4;

  int checks = 0;
  int errors = 0;
  int done_cnt4 = 0;
  logic [15:0] last;

  nbit_mult_sequencer #(.N(8)) u_dut (
    .clk(clk), .reset(reset), .start(start), .inputM(inputM), .inputQ(inputQ),
    .busy(busy), .done(done), .product(product)
  );

  nbit_mult_sequencer #(.N(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .inputM(m4), .inputQ(q4),
    .busy(busy4), .done(done4), .product(prod4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (done4) done_cnt4 <= done_cnt4 + 1;

  typedef struct {
    logic [7:0]  m;
    logic [7:0]  q;
    logic [15:0] prod;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [7:0] q, input int n);
`ifdef MULT_SEQ_SKIP_ZERO_EN
    int b;
    b = -1;
    for (int i = 0; i < n; i++) if (q[i]) b = i;
    if (b < 0) return 1;
    return (b + 2 < n) ? b + 2 : n;
`else
    return n;
`endif
  endfunction

  // One operation on the N=8 unit: start pulse, then watch busy/done/product until done.
  task automatic run_op(input logic [7:0] m, input logic [7:0] q, input logic [15:0] prev,
                        output logic [15:0] prod, output int lat);
    int busy_cnt;
    bit hold_ok, overlap;
    @(negedge clk);
    inputM = m;
    inputQ = q;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    inputM = ~m;
    inputQ = ~q;
    busy_cnt = busy ? 1 : 0;
    hold_ok  = (product === prev);
    overlap  = 1'b0;
    lat      = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (done && busy) overlap = 1'b1;
      if (!done) begin
        if (busy) busy_cnt++;
        if (product !== prev) hold_ok = 1'b0;
      end
    end
    prod = product;
    chk("latency", lat, exp_lat(q, 8));
    chk("product", prod, m * q);
    chk("busy_cycles", busy_cnt, exp_lat(q, 8));
    chk("product_hold", hold_ok, 1);
    chk("done_busy_overlap", overlap, 0);
    @(posedge clk);
    #1;
    chk("done_one_cycle", done, 0);
    chk("prod_after_done", product, m * q);
  endtask

  initial begin
    vec_t vecs[10];
    logic [15:0] p;
    int lat;
    bit saw_done;

    vecs[0] = '{m: 8'd13,  q: 8'd11,  prod: 16'd143};
    vecs[1] = '{m: 8'd255, q: 8'd255, prod: 16'd65025};
    vecs[2] = '{m: 8'd0,   q: 8'd200, prod: 16'd0};
    vecs[3] = '{m: 8'd3,   q: 8'd5,   prod: 16'd15};
    vecs[4] = '{m: 8'd77,  q: 8'd0,   prod: 16'd0};
    vecs[5] = '{m: 8'd100, q: 8'd3,   prod: 16'd300};
    vecs[6] = '{m: 8'd2,   q: 8'd128, prod: 16'd256};
    vecs[7] = '{m: 8'd1,   q: 8'd1,   prod: 16'd1};
    vecs[8] = '{m: 8'd200, q: 8'd123, prod: 16'd24600};
    vecs[9] = '{m: 8'd128, q: 8'd255, prod: 16'd32640};

    reset  = 1'b1;
    start  = 1'b0;
    inputM = '0;
    inputQ = '0;
    start4 = 1'b0;
    m4     = '0;
    q4     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_product", product, 0);
    @(negedge clk);
    reset = 1'b0;
    last  = 16'd0;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].m, vecs[i].q, last, p, lat);
      chk("table_product", p, vecs[i].prod);
      last = p;
    end

    // start held high: DONE must not accept, IDLE must, and captured operands are immune to later changes.
    @(negedge clk);
    inputM = 8'd3;
    inputQ = 8'd5;
    start  = 1'b1;
    saw_done = 1'b0;
    for (int c = 0; c < 40 && !saw_done; c++) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    chk("held_first_done", saw_done, 1);
    chk("held_first_product", product, 15);
    chk("held_done_no_busy", busy, 0);
    @(posedge clk);
    #1;
    chk("held_idle_busy", busy, 0);
    chk("held_idle_done", done, 0);
    @(posedge clk);
    #1;
    chk("held_accept_busy", busy, 1);
    inputM = 8'd9;
    inputQ = 8'd9;
    saw_done = 1'b0;
    for (int c = 0; c < 40 && !saw_done; c++) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    chk("held_second_done", saw_done, 1);
    chk("held_second_product", product, 15);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Asynchronous reset after four ADD edges aborts the operation with no done pulse.
    @(negedge clk);
    inputM = 8'd200;
    inputQ = 8'd200;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    chk("pre_abort_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_product", product, 0);
    @(negedge clk);
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    chk("abort_no_done", saw_done, 0);
    run_op(8'd7, 8'd9, 16'd0, p, lat);
    chk("after_abort_product", p, 63);

    // Exhaustive N=4, operations back-to-back with start held high.
    @(negedge clk);
    start4 = 1'b1;
    for (int i = 0; i < 256; i++) begin
      int w;
      m4 = 4'(i >> 4);
      q4 = 4'(i);
      w = 0;
      do begin
        @(posedge clk);
        #1;
        w++;
      end while (!done4 && w < 20);
      chk("n4_product", prod4, (i >> 4) * (i & 15));
    end
    start4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("n4_done_count", done_cnt4, 256);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
